// File: rtl/mmio_router_if.sv
// CPU-side IO bus of mmio_router: address, write data and control in, read data out.
interface mmio_router_if;
    logic [31:0] address_io;
    logic [15:0] data_in_io;
    logic [1:0]  control_io;  // {write, byte}
    logic [15:0] data_out_io;

    modport master (
        output address_io,
        output data_in_io,
        output control_io,
        input  data_out_io
    );

    modport slave (
        input  address_io,
        input  data_in_io,
        input  control_io,
        output data_out_io
    );
endinterface

// File: rtl/mmio_router.sv
// IO address decoder: registered per-slot write strobes, pipelined read-data select, internal
// slot 0 (LEDs, sticky error block). Define MMIO_WRITE_LOCK_EN to add the per-slot write lock.
module mmio_router #(
    parameter int unsigned NUM_DEV      = 8,
    parameter int unsigned SEL_LSB      = 23,
    parameter int unsigned SEL_W        = 3,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned LED_W        = 10
) (
    input  logic                    main_clk,
    input  logic                    main_rst_n,
    mmio_router_if.slave            cpu,
    output logic [NUM_DEV-1:0]      dev_write,
    output logic                    dev_byte,
    output logic [SEL_LSB-1:0]      dev_addr,
    output logic [15:0]             dev_wdata,
    input  logic [16*NUM_DEV-1:0]   dev_rdata,
    input  logic [NUM_DEV-1:0]      dev_present,
    output logic [LED_W-1:0]        led_out_state,
    output logic                    err_irq
);

    typedef struct packed {
        logic             io;
        logic             valid;
        logic [SEL_W-1:0] slot;
        logic             a0;
        logic             byt;
        logic [15:0]      s0;
    } rd_stage_t;

    logic               io_acc, wr, byt;
    logic [SEL_W-1:0]   slot;
    logic [7:0]         offset;
    logic [15:0]        wdata;
    logic               slot_ok, locked, wr_ok, s0_wr, err_hit, err_clr;
    logic [15:0]        s0_rdata;
    logic [NUM_DEV-1:0] lock_mask;

    logic [NUM_DEV-1:0] dev_write_d, dev_write_q;
    logic               dev_byte_q;
    logic [SEL_LSB-1:0] dev_addr_q;
    logic [15:0]        dev_wdata_q;
    logic [LED_W-1:0]   led_d, led_q;
    logic [7:0]         err_count_d, err_count_q;
    logic [3:0]         err_slot_d, err_slot_q;
    logic [15:0]        err_addr_d, err_addr_q;
    rd_stage_t          rd_d, rd_last;
    rd_stage_t          rd_q [READ_LATENCY];
    logic [15:0]        rd_sel;
    logic               unused_bits;

    assign io_acc = cpu.address_io[31];
    assign slot   = cpu.address_io[SEL_LSB+SEL_W-1:SEL_LSB];
    assign offset = cpu.address_io[7:0];
    assign wr     = cpu.control_io[1];
    assign byt    = cpu.control_io[0];
    assign wdata  = {byt ? cpu.data_in_io[7:0] : cpu.data_in_io[15:8], cpu.data_in_io[7:0]};

    // Slot 0's dev_rdata field and present bit are replaced by internal logic.
    assign unused_bits = ^{cpu.address_io, dev_rdata[15:0], dev_present[0]};

`ifdef MMIO_WRITE_LOCK_EN
    logic [NUM_DEV-1:0] lock_mask_d, lock_mask_q;

    always_comb begin
        lock_mask_d = lock_mask_q;
        if (s0_wr && !byt && offset == 8'h30) begin
            lock_mask_d = wdata[NUM_DEV-1:0];
        end
        lock_mask_d[0] = 1'b0;
    end

    always_ff @(posedge main_clk or negedge main_rst_n) begin
        if (!main_rst_n) begin
            lock_mask_q <= '0;
        end else begin
            lock_mask_q <= lock_mask_d;
        end
    end

    assign lock_mask = lock_mask_q;
`else
    assign lock_mask = '0;
`endif

    always_comb begin
        slot_ok = 1'b0;
        locked  = 1'b0;
        for (int unsigned i = 0; i < NUM_DEV; i++) begin
            if (slot == SEL_W'(i)) begin
                slot_ok = (i == 0) || dev_present[i];
                locked  = lock_mask[i];
            end
        end
    end

    assign wr_ok   = io_acc && wr && slot_ok && !locked;
    assign s0_wr   = wr_ok && (slot == '0);
    assign err_hit = io_acc && (!slot_ok || (wr && locked));
    assign err_clr = s0_wr && (offset == 8'h20);

    always_comb begin
        dev_write_d = '0;
        for (int unsigned i = 1; i < NUM_DEV; i++) begin
            dev_write_d[i] = wr_ok && (slot == SEL_W'(i));
        end
    end

    always_comb begin
        led_d = led_q;
        for (int unsigned i = 0; i < LED_W; i++) begin
            if (s0_wr && offset == 8'(i)) begin
                led_d[i] = wdata[0];
            end
        end
    end

    always_comb begin
        err_count_d = err_count_q;
        err_slot_d  = err_slot_q;
        err_addr_d  = err_addr_q;
        if (err_clr) begin
            err_count_d = '0;
            err_slot_d  = '0;
            err_addr_d  = '0;
        end else if (err_hit) begin
            if (err_count_q != 8'hFF) begin
                err_count_d = err_count_q + 8'd1;
            end
            err_slot_d = 4'(slot);
            err_addr_d = cpu.address_io[15:0];
        end
    end

    // Sampled from current state so a read right after a write sees the update.
    always_comb begin
        s0_rdata = '0;
        case (offset)
            8'h10:   s0_rdata = {err_count_q, 4'h0, err_slot_q};
            8'h12:   s0_rdata = err_addr_q;
`ifdef MMIO_WRITE_LOCK_EN
            8'h30:   s0_rdata = 16'(lock_mask_q);
`endif
            default: s0_rdata = '0;
        endcase
    end

    always_comb begin
        rd_d       = '0;
        rd_d.io    = io_acc;
        rd_d.valid = slot_ok;
        rd_d.slot  = slot;
        rd_d.a0    = cpu.address_io[0];
        rd_d.byt   = byt;
        rd_d.s0    = s0_rdata;
    end

    always_ff @(posedge main_clk or negedge main_rst_n) begin
        if (!main_rst_n) begin
            dev_write_q <= '0;
            dev_byte_q  <= 1'b0;
            dev_addr_q  <= '0;
            dev_wdata_q <= '0;
            led_q       <= '0;
            err_count_q <= '0;
            err_slot_q  <= '0;
            err_addr_q  <= '0;
            for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                rd_q[i] <= '0;
            end
        end else begin
            dev_write_q <= dev_write_d;
            dev_byte_q  <= byt;
            dev_addr_q  <= cpu.address_io[SEL_LSB-1:0];
            dev_wdata_q <= wdata;
            led_q       <= led_d;
            err_count_q <= err_count_d;
            err_slot_q  <= err_slot_d;
            err_addr_q  <= err_addr_d;
            rd_q[0]     <= rd_d;
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                rd_q[i] <= rd_q[i-1];
            end
        end
    end

    // Device read data is selected live at the final stage.
    always_comb begin
        rd_last = rd_q[READ_LATENCY-1];
        rd_sel  = 16'hFFFF;
        if (rd_last.valid) begin
            rd_sel = rd_last.s0;
            for (int unsigned i = 1; i < NUM_DEV; i++) begin
                if (rd_last.slot == SEL_W'(i)) begin
                    rd_sel = dev_rdata[16*i +: 16];
                end
            end
        end
        cpu.data_out_io = '0;
        if (rd_last.io) begin
            cpu.data_out_io = rd_last.byt ? {8'h00, rd_last.a0 ? rd_sel[15:8] : rd_sel[7:0]}
                                          : rd_sel;
        end
    end

    assign dev_write     = dev_write_q;
    assign dev_byte      = dev_byte_q;
    assign dev_addr      = dev_addr_q;
    assign dev_wdata     = dev_wdata_q;
    assign led_out_state = led_q;
    assign err_irq       = (err_count_q != 8'd0);

endmodule

// File: tb/tb_mmio_router.sv
// Self-checking bench for mmio_router: directed scenarios followed by random traffic, compared
// against a behavioural model of the decode, error and read-latency rules.
module tb_mmio_router;

    localparam int unsigned L = 3;

    typedef struct {
        bit        io;
        bit        valid;
        bit        a0;
        bit        byt;
        bit [2:0]  slot;
        bit [15:0] s0;
    } rd_t;

    logic         main_clk = 1'b0;
    logic         main_rst_n;
    logic [7:0]   dev_write;
    logic         dev_byte;
    logic [22:0]  dev_addr;
    logic [15:0]  dev_wdata;
    logic [127:0] dev_rdata;
    logic [7:0]   dev_present;
    logic [9:0]   led_out_state;
    logic         err_irq;

    int vectors    = 0;
    int miscompares = 0;
    bit rnd_rdata  = 0;

    // Reference model state
    bit [9:0]  m_led;
    int        m_errc;
    bit [3:0]  m_eslot;
    bit [15:0] m_eaddr;
    bit [7:0]  m_lock;
    bit [7:0]  m_write;
    bit        m_byte;
    bit [22:0] m_addr;
    bit [15:0] m_wdata;
    rd_t       q[$];

    mmio_router_if bus ();

    mmio_router #(
        .NUM_DEV      (8),
        .SEL_LSB      (23),
        .SEL_W        (3),
        .READ_LATENCY (L),
        .LED_W        (10)
    ) dut (
        .main_clk      (main_clk),
        .main_rst_n    (main_rst_n),
        .cpu           (bus),
        .dev_write     (dev_write),
        .dev_byte      (dev_byte),
        .dev_addr      (dev_addr),
        .dev_wdata     (dev_wdata),
        .dev_rdata     (dev_rdata),
        .dev_present   (dev_present),
        .led_out_state (led_out_state),
        .err_irq       (err_irq)
    );

    always #5 main_clk = ~main_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] s0_read(input bit [7:0] off);
        if (off == 8'h10) return {m_errc[7:0], 4'h0, m_eslot};
        if (off == 8'h12) return m_eaddr;
`ifdef MMIO_WRITE_LOCK_EN
        if (off == 8'h30) return {8'h00, m_lock};
`endif
        return 16'h0000;
    endfunction

    function automatic logic [15:0] exp_read(input rd_t r);
        logic [15:0] v;
        if (!r.io) return 16'h0000;
        if (!r.valid) v = 16'hFFFF;
        else if (r.slot == 0) v = r.s0;
        else v = dev_rdata[int'(r.slot)*16 +: 16];
        if (r.byt) return {8'h00, r.a0 ? v[15:8] : v[7:0]};
        return v;
    endfunction

    task automatic model_reset();
        rd_t idle;
        idle = '{default: 0};
        m_led = '0; m_errc = 0; m_eslot = '0; m_eaddr = '0; m_lock = '0;
        m_write = '0; m_byte = 0; m_addr = '0; m_wdata = '0;
        q.delete();
        for (int i = 0; i < int'(L) - 1; i++) q.push_back(idle);
    endtask

    task automatic set_idle();
        bus.address_io = '0;
        bus.data_in_io = '0;
        bus.control_io = '0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_data_out"}, bus.data_out_io, 0);
        chk({tag, "_dev_write"}, dev_write, 0);
        chk({tag, "_dev_byte"}, dev_byte, 0);
        chk({tag, "_dev_addr"}, dev_addr, 0);
        chk({tag, "_dev_wdata"}, dev_wdata, 0);
        chk({tag, "_led"}, led_out_state, 0);
        chk({tag, "_err_irq"}, err_irq, 0);
    endtask

    // One request cycle: drive, predict, clock, compare.
    task automatic do_cycle(input logic [31:0] a, input logic [15:0] d, input bit w, input bit b);
        rd_t       r, o;
        bit [2:0]  s;
        bit [7:0]  off;
        bit [15:0] wd;
        bit        ok, lk;
        if (rnd_rdata) dev_rdata = {$urandom, $urandom, $urandom, $urandom};
        bus.address_io = a;
        bus.data_in_io = d;
        bus.control_io = {w, b};
        s   = a[25:23];
        off = a[7:0];
        wd  = {b ? d[7:0] : d[15:8], d[7:0]};
        ok  = (s == 0) || dev_present[s];
        lk  = m_lock[s];
        r.io = a[31]; r.valid = ok; r.a0 = a[0]; r.byt = b; r.slot = s; r.s0 = s0_read(off);
        q.push_back(r);
        m_write = '0; m_byte = b; m_addr = a[22:0]; m_wdata = wd;
        if (a[31]) begin
            if (!ok || (w && lk)) begin
                if (m_errc < 255) m_errc++;
                m_eslot = {1'b0, s};
                m_eaddr = a[15:0];
            end else if (w) begin
                if (s != 0) begin
                    m_write[s] = 1'b1;
                end else begin
                    if (off < 10) m_led[off] = wd[0];
                    if (off == 8'h20) begin
                        m_errc = 0; m_eslot = '0; m_eaddr = '0;
                    end
`ifdef MMIO_WRITE_LOCK_EN
                    if (off == 8'h30 && !b) m_lock = wd[7:0] & 8'hFE;
`endif
                end
            end
        end
        @(posedge main_clk);
        #1;
        o = q.pop_front();
        chk("dev_write", dev_write, m_write);
        chk("dev_byte", dev_byte, m_byte);
        chk("dev_addr", dev_addr, m_addr);
        chk("dev_wdata", dev_wdata, m_wdata);
        chk("led", led_out_state, m_led);
        chk("err_irq", err_irq, m_errc != 0);
        chk("data_out", bus.data_out_io, exp_read(o));
    endtask

    task automatic idle_cycle();
        do_cycle(32'h0, 16'h0, 0, 0);
    endtask

    task automatic rand_cycle();
        bit        io;
        bit [2:0]  s;
        bit [22:0] lo;
        bit [7:0]  off;
        io = ($urandom_range(0, 4) != 0);
        s  = 3'($urandom_range(0, 7));
        lo = 23'($urandom);
        if (s == 0) begin
            case ($urandom_range(0, 6))
                0, 1:    off = 8'($urandom_range(0, 15));
                2:       off = 8'h10;
                3:       off = 8'h12;
                4:       off = 8'h20;
                5:       off = 8'h30;
                default: off = 8'($urandom);
            endcase
            lo[7:0] = off;
        end
        if ($urandom_range(0, 15) == 0) dev_present = 8'($urandom);
        do_cycle({io, 5'($urandom), s, lo}, 16'($urandom), 1'($urandom), 1'($urandom));
    endtask

    initial begin
        main_rst_n  = 1'b0;
        dev_present = 8'hDF;
        dev_rdata   = '0;
        set_idle();
        #7;
        check_reset("por");
        #16 main_rst_n = 1'b1;
        model_reset();

        // Warm-up traffic, then reset in the middle of it
        rnd_rdata = 1;
        repeat (40) rand_cycle();
        #2 main_rst_n = 1'b0;
        #1 check_reset("mid");
        set_idle();
        #20 main_rst_n = 1'b1;
        model_reset();
        rnd_rdata   = 0;
        dev_present = 8'hDF;
        dev_rdata   = '0;
        dev_rdata[47:32] = 16'hABCD;

        do_cycle(32'h8080_0004, 16'h1234, 1, 0);
        chk("tp_first_write", dev_write, 8'b0000_0010);
        chk("tp_first_addr", dev_addr, 23'd4);
        chk("tp_first_wdata", dev_wdata, 16'h1234);

        // Byte reads of slot 2, latency 3
        do_cycle(32'h8100_0000, 16'h0, 0, 1);
        do_cycle(32'h8100_0001, 16'h0, 0, 1);
        idle_cycle();
        chk("tp_byte_lo", bus.data_out_io, 16'h00CD);
        idle_cycle();
        chk("tp_byte_hi", bus.data_out_io, 16'h00AB);

        do_cycle(32'h8180_0000, 16'h005A, 1, 1);
        chk("tp_byte_wdata", dev_wdata, 16'h5A5A);
        chk("tp_byte_write", dev_write, 8'h08);
        do_cycle(32'h8000_0003, 16'h0001, 1, 0);
        chk("tp_led3", led_out_state, 10'h008);
        do_cycle(32'h8000_000C, 16'h0001, 1, 0);
        chk("tp_led12", led_out_state, 10'h008);

        // Absent slot 5
        do_cycle(32'h8280_0000, 16'h0, 0, 0);
        chk("tp_irq_set", err_irq, 1'b1);
        do_cycle(32'h8000_0010, 16'h0, 0, 0);
        idle_cycle();
        chk("tp_absent_read", bus.data_out_io, 16'hFFFF);
        idle_cycle();
        chk("tp_err_status", bus.data_out_io, 16'h0105);
        do_cycle(32'h8000_0020, 16'h0, 1, 0);
        chk("tp_irq_clear", err_irq, 1'b0);

        // Saturation
        for (int i = 0; i < 300; i++) do_cycle(32'h8280_0000, 16'($urandom), 1'($urandom), 0);
        do_cycle(32'h8000_0010, 16'h0, 0, 0);
        idle_cycle();
        idle_cycle();
        chk("tp_saturate", bus.data_out_io, 16'hFF05);
        do_cycle(32'h8000_0020, 16'h0, 1, 0);
        chk("tp_sat_clear", err_irq, 1'b0);

`ifdef MMIO_WRITE_LOCK_EN
        do_cycle(32'h8000_0030, 16'h0004, 1, 0);
        do_cycle(32'h8100_0000, 16'hBEEF, 1, 0);
        chk("tp_lock_drop", dev_write, 8'h00);
        do_cycle(32'h8100_0000, 16'h0, 0, 0);
        do_cycle(32'h8000_0010, 16'h0, 0, 0);
        idle_cycle();
        chk("tp_lock_read", bus.data_out_io, 16'hABCD);
        idle_cycle();
        chk("tp_lock_errslot", bus.data_out_io, 16'h0102);
`endif

        // Random traffic against the model
        rnd_rdata = 1;
        repeat (3000) rand_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
